// File: rtl/led_button_event_gen.sv
// Button front end: two-flop sync, debounce, press pulse and hold-to-repeat
// for the up/down brightness commands, with mutual lockout when both are held.
module led_button_event_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned REPEAT_DELAY    = 16,
   parameter int unsigned REPEAT_RATE     = 4,
   parameter int unsigned CNT_W           = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   output logic bright_up,
   output logic bright_down,
   output logic up_held,
   output logic down_held
);

   localparam int unsigned NB = 2;
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;
   localparam logic [1:0] ST_LOCKED = 2'd3;

   // Index 0 is the up button, index 1 the down button.
   logic [NB-1:0]    raw;
   logic [NB-1:0]    s1_q, s2_q;
   logic [NB-1:0]    stable_q, stable_d;
   logic [NB-1:0]    pulse_q, pulse_d;
   logic [CNT_W-1:0] deb_cnt_q [NB];
   logic [CNT_W-1:0] deb_cnt_d [NB];
   logic [CNT_W-1:0] rep_cnt_q [NB];
   logic [CNT_W-1:0] rep_cnt_d [NB];
   logic [1:0]       state_q   [NB];
   logic [1:0]       state_d   [NB];
   logic             both_held;

   assign raw         = {btn_down_raw, btn_up_raw};
   assign both_held   = &stable_q;
   assign bright_up   = pulse_q[0];
   assign bright_down = pulse_q[1];
   assign up_held     = stable_q[0];
   assign down_held   = stable_q[1];

   // Debounce: stable flips after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      stable_d = stable_q;
      for (int unsigned i = 0; i < NB; i++) begin
         deb_cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               stable_d[i] = s2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   // Per-button press/repeat FSM; a release or a conflict overrides every state.
   always_comb begin
      pulse_d = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         state_d[i]   = state_q[i];
         rep_cnt_d[i] = rep_cnt_q[i];
         if (!stable_q[i]) begin
            state_d[i]   = ST_IDLE;
            rep_cnt_d[i] = '0;
         end else if (both_held) begin
            state_d[i]   = ST_LOCKED;
            rep_cnt_d[i] = '0;
         end else begin
            case (state_q[i])
               ST_IDLE: begin
                  pulse_d[i]   = 1'b1;
                  state_d[i]   = ST_DELAY;
                  rep_cnt_d[i] = '0;
               end
               ST_DELAY: begin
                  if (rep_cnt_q[i] == DLY_LAST) begin
                     pulse_d[i]   = 1'b1;
                     state_d[i]   = ST_REPEAT;
                     rep_cnt_d[i] = '0;
                  end else begin
                     rep_cnt_d[i] = rep_cnt_q[i] + CNT_ONE;
                  end
               end
               ST_REPEAT: begin
                  if (rep_cnt_q[i] == RATE_LAST) begin
                     pulse_d[i]   = 1'b1;
                     rep_cnt_d[i] = '0;
                  end else begin
                     rep_cnt_d[i] = rep_cnt_q[i] + CNT_ONE;
                  end
               end
               ST_LOCKED: begin
                  rep_cnt_d[i] = '0;
               end
               default: begin
                  state_d[i]   = ST_IDLE;
                  rep_cnt_d[i] = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q     <= '0;
         s2_q     <= '0;
         stable_q <= '0;
         pulse_q  <= '0;
         for (int unsigned i = 0; i < NB; i++) begin
            deb_cnt_q[i] <= '0;
            rep_cnt_q[i] <= '0;
            state_q[i]   <= ST_IDLE;
         end
      end else begin
         s1_q     <= raw;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         pulse_q  <= pulse_d;
         for (int unsigned i = 0; i < NB; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
            rep_cnt_q[i] <= rep_cnt_d[i];
            state_q[i]   <= state_d[i];
         end
      end
   end

endmodule

// File: tb/tb_led_button_event_gen.sv
// Scoreboard bench for led_button_event_gen: a per-edge reference model pushes
// expected outputs; an independent monitor pops and compares on the falling edge.
module tb_led_button_event_gen;

   localparam int DEB = 4;
   localparam int RD  = 16;
   localparam int RR  = 4;

   logic clk;
   logic reset_n;
   logic btn_up_raw;
   logic btn_down_raw;
   logic bright_up;
   logic bright_down;
   logic up_held;
   logic down_held;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [3:0] sb_q [$];

   // Reference model state (index 0 = up, 1 = down)
   bit m_s1   [2];
   bit m_s2   [2];
   bit m_st   [2];
   bit m_hist [2][DEB];
   bit m_lock [2];
   bit m_pulse[2];
   int m_age  [2];

   led_button_event_gen #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (RD),
      .REPEAT_RATE    (RR),
      .CNT_W          (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_up_raw  (btn_up_raw),
      .btn_down_raw(btn_down_raw),
      .bright_up   (bright_up),
      .bright_down (bright_down),
      .up_held     (up_held),
      .down_held   (down_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0;
         m_lock[i] = 0; m_pulse[i] = 0; m_age[i] = -1;
         for (int k = 0; k < DEB; k++) m_hist[i][k] = 0;
      end
   endfunction

   // One rising edge: raw levels are those present just before the edge.
   function automatic void model_step(bit up, bit dn);
      bit raw [2];
      bit old_st [2];
      bit new_st [2];
      bit all_diff;
      bit both;
      raw[0] = up; raw[1] = dn;
      for (int i = 0; i < 2; i++) old_st[i] = m_st[i];
      for (int i = 0; i < 2; i++) begin
         for (int k = DEB - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
         m_hist[i][0] = m_s2[i];
         all_diff = 1;
         for (int k = 0; k < DEB; k++) if (m_hist[i][k] == old_st[i]) all_diff = 0;
         new_st[i] = all_diff ? !old_st[i] : old_st[i];
      end
      both = old_st[0] && old_st[1];
      for (int i = 0; i < 2; i++) begin
         m_pulse[i] = 0;
         if (!old_st[i]) begin
            m_lock[i] = 0; m_age[i] = -1;
         end else if (both) begin
            m_lock[i] = 1; m_age[i] = -1;
         end else if (m_lock[i]) begin
            m_age[i] = -1;
         end else if (m_age[i] < 0) begin
            m_age[i] = 0; m_pulse[i] = 1;
         end else begin
            m_age[i]++;
            if (m_age[i] >= RD && ((m_age[i] - RD) % RR) == 0) m_pulse[i] = 1;
         end
      end
      for (int i = 0; i < 2; i++) begin
         m_s2[i] = m_s1[i];
         m_s1[i] = raw[i];
         m_st[i] = new_st[i];
      end
   endfunction

   // Drive one cycle of stimulus (rst=0 holds the DUT in reset) and score the edge.
   task automatic cycle(input bit up, input bit dn, input bit rst);
      @(negedge clk);
      btn_up_raw   = up;
      btn_down_raw = dn;
      reset_n      = rst;
      if (!rst) begin
         model_reset();
         #1;
         checks++;
         if ({bright_up, bright_down, up_held, down_held} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs t=%0t: got %b%b%b%b want 0000",
                     $time, bright_up, bright_down, up_held, down_held);
         end
      end
      @(posedge clk);
      cyc++;
      if (reset_n) begin
         model_step(up, dn);
         sb_q.push_back({m_pulse[0], m_pulse[1], m_st[0], m_st[1]});
      end else begin
         sb_q.push_back(4'b0000);
      end
   endtask

   task automatic hold(input bit up, input bit dn, input int n);
      repeat (n) cycle(up, dn, 1'b1);
   endtask

   // Monitor: compare each scored edge and check the outputs' mutual exclusion.
   initial begin
      logic [3:0] exp_v;
      logic [3:0] got_v;
      forever begin
         @(negedge clk);
         checks++;
         if (bright_up === 1'b1 && bright_down === 1'b1) begin
            errors++;
            $display("FAIL exclusive cyc=%0d: got both pulses high want at most one", cyc);
         end
         if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            got_v = {bright_up, bright_down, up_held, down_held};
            checks++;
            if (got_v !== exp_v) begin
               errors++;
               $display("FAIL outputs cyc=%0d: got up/dn/uh/dh=%b want %b", cyc, got_v, exp_v);
            end
         end
      end
   end

   initial begin
      int w;
      int len;
      bit up;
      bit dn;
      reset_n      = 1'b0;
      btn_up_raw   = 1'b0;
      btn_down_raw = 1'b0;
      model_reset();
      repeat (3) cycle(0, 0, 0);
      hold(0, 0, 3);

      // Clean press, then release
      hold(1, 0, 10);
      hold(0, 0, 12);
      // Bounce on down, then hold
      cycle(0, 1, 1); cycle(0, 0, 1); cycle(0, 1, 1); cycle(0, 0, 1);
      hold(0, 1, 12);
      hold(0, 0, 12);
      // Auto-repeat
      hold(1, 0, 40);
      hold(0, 0, 12);
      // Conflict during repeat, release up, then re-press down
      hold(1, 0, 30);
      hold(1, 1, 20);
      hold(0, 1, 20);
      hold(0, 0, 10);
      hold(0, 1, 12);
      hold(0, 0, 10);
      // Reset mid-hold, release with up still held
      hold(1, 0, 30);
      repeat (3) cycle(1, 0, 0);
      hold(1, 0, 40);
      hold(0, 0, 10);
      // Simultaneous press
      hold(1, 1, 25);
      hold(0, 0, 10);

      // Randomized segments: long holds, short glitches, occasional resets
      for (int s = 0; s < 250; s++) begin
         up = 1'($urandom_range(0, 1));
         dn = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) < 5) begin
            repeat ($urandom_range(1, 3)) cycle(up, dn, 0);
         end else begin
            len = ($urandom_range(0, 99) < 25) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(5, 45));
            hold(up, dn, len);
         end
      end
      hold(0, 0, 12);

      w = 0;
      while (sb_q.size() != 0 && w < 10) begin
         @(posedge clk);
         w++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
